// File: rtl/mem_access_unit.sv
// Data-memory access: drives the DMEM port from X (store alignment, byte enables)
// and extracts sign/zero-extended load results in M, holding the read word across stalls.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_X,
  input  logic [31:0] addr_X,
  input  logic [31:0] rs2_X,
  input  logic        data_fwd,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] dmem_dout,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_din,
  output logic [3:0]  dmem_we,
  output logic [31:0] inst_M,
  output logic [31:0] load_data_M,
  output logic        misalign
);

  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [31:0] INST_NOP = 32'h00000013;

  logic [2:0]  funct3_X;
  logic [1:0]  off_X;
  logic        is_load_X;
  logic        is_store_X;
  logic        misal_X;
  logic [31:0] store_src;
  logic [3:0]  we_raw;

  logic [2:0]  funct3_M;
  logic [1:0]  off_M;
  logic        is_load_M;
  logic        misal_M;
  logic        stall_q;
  logic [31:0] ld_hold;

  logic [31:0] rd;
  logic [31:0] rd_byte_sh;
  logic [31:0] rd_half_sh;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign funct3_X   = inst_X[14:12];
  assign off_X      = addr_X[1:0];
  assign is_load_X  = (inst_X[6:0] == OP_LOAD);
  assign is_store_X = (inst_X[6:0] == OP_STORE);
  assign dmem_addr  = {addr_X[31:2], 2'b00};

  always_comb begin
    misal_X = 1'b0;
    if (is_store_X) begin
      misal_X = ((funct3_X == 3'b001) && off_X[0]) ||
                ((funct3_X == 3'b010) && (off_X != 2'b00));
    end else if (is_load_X) begin
      misal_X = (((funct3_X == 3'b001) || (funct3_X == 3'b101)) && off_X[0]) ||
                ((funct3_X == 3'b010) && (off_X != 2'b00));
    end
  end

  // Forwarded store data comes from the load currently in M (same-cycle path).
  assign store_src = data_fwd ? load_data_M : rs2_X;

  always_comb begin
    dmem_din = store_src;
    we_raw   = 4'b0000;
    case (funct3_X)
      3'b000: begin
        dmem_din = {4{store_src[7:0]}};
        we_raw   = 4'b0001 << off_X;
      end
      3'b001: begin
        dmem_din = {2{store_src[15:0]}};
        we_raw   = off_X[1] ? 4'b1100 : 4'b0011;
      end
      3'b010:  we_raw = 4'b1111;
      default: we_raw = 4'b0000;
    endcase
    dmem_we = (is_store_X && !stall && !misal_X) ? we_raw : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_M    <= INST_NOP;
      funct3_M  <= 3'b000;
      off_M     <= 2'b00;
      is_load_M <= 1'b0;
      misal_M   <= 1'b0;
      stall_q   <= 1'b0;
      ld_hold   <= 32'h0;
      misalign  <= 1'b0;
    end else begin
      stall_q <= stall;
      // DMEM re-reads the stalled X address, so keep the word from the first M cycle.
      if (stall && !stall_q) ld_hold <= dmem_dout;
      if (!stall) begin
        if (misal_X) misalign <= 1'b1;
        funct3_M <= funct3_X;
        off_M    <= off_X;
        if (flush) begin
          inst_M    <= INST_NOP;
          is_load_M <= 1'b0;
          misal_M   <= 1'b0;
        end else begin
          inst_M    <= inst_X;
          is_load_M <= is_load_X;
          misal_M   <= misal_X;
        end
      end
    end
  end

  assign rd         = stall_q ? ld_hold : dmem_dout;
  assign rd_byte_sh = rd >> {off_M, 3'b000};
  assign rd_half_sh = rd >> {off_M[1], 4'b0000};
  assign byte_sel   = rd_byte_sh[7:0];
  assign half_sel   = rd_half_sh[15:0];

  always_comb begin
    load_data_M = 32'h0;
    if (is_load_M && !misal_M) begin
      case (funct3_M)
        3'b000:  load_data_M = {{24{byte_sel[7]}}, byte_sel};
        3'b100:  load_data_M = {24'h0, byte_sel};
        3'b001:  load_data_M = {{16{half_sel[15]}}, half_sel};
        3'b101:  load_data_M = {16'h0, half_sel};
        3'b010:  load_data_M = rd;
        default: load_data_M = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: store-vector table, directed load/forward/stall/flush/reset
// sequences, then randomized traffic against a byte-level reference model.
module tb_mem_access_unit;

  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_X, addr_X, rs2_X, dmem_dout;
  logic        data_fwd, stall, flush;
  logic [31:0] dmem_addr, dmem_din, inst_M, load_data_M;
  logic [3:0]  dmem_we;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .inst_X(inst_X), .addr_X(addr_X), .rs2_X(rs2_X),
    .data_fwd(data_fwd), .stall(stall), .flush(flush), .dmem_dout(dmem_dout),
    .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_we(dmem_we),
    .inst_M(inst_M), .load_data_M(load_data_M), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [3:0]  we;
    logic [31:0] din;
    logic        chk_din;
  } st_vec_t;

  st_vec_t vecs[9];

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rs2f);
    return {7'h0, rs2f, 5'd1, f3, 5'd0, op};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Access size in bytes for a valid load/store, 0 if the encoding is not a memory access.
  function automatic int acc_size(input logic [31:0] inst);
    int f3;
    f3 = int'(inst[14:12]);
    if (inst[6:0] == OP_STORE && f3 <= 2) return 1 << f3;
    if (inst[6:0] == OP_LOAD && (f3 <= 2 || f3 == 4 || f3 == 5)) return 1 << (f3 % 4);
    return 0;
  endfunction

  function automatic bit is_mis(input logic [31:0] inst, input logic [31:0] addr);
    int sz;
    sz = acc_size(inst);
    return (sz != 0) && ((addr % sz) != 0);
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] inst, input logic [1:0] off, input logic [31:0] word);
    int sz;
    logic [31:0] v, mask;
    if (inst[6:0] != OP_LOAD) return 32'h0;
    sz = acc_size(inst);
    if (sz == 0 || (int'(off) % sz) != 0) return 32'h0;
    v = word >> (8 * int'(off));
    if (sz == 4) return v;
    mask = (32'h1 << (8 * sz)) - 32'h1;
    v = v & mask;
    if (inst[14] == 1'b0 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic store_exp(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] src,
                           input logic stl, output logic [3:0] we, output logic [31:0] din);
    int sz, off;
    we  = 4'h0;
    din = 32'h0;
    sz  = acc_size(inst);
    off = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) din[8*i +: 8] = src[8*(i % (sz == 0 ? 4 : sz)) +: 8];
    if (stl || inst[6:0] != OP_STORE || sz == 0 || (off % sz) != 0) return;
    for (int i = 0; i < sz; i++) we[off + i] = 1'b1;
  endtask

  task automatic do_reset();
    inst_X = NOP; addr_X = 0; rs2_X = 0; data_fwd = 0; stall = 0; flush = 0; dmem_dout = 0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    next();
  endtask

  logic [31:0] m_inst, m_word, exp_ld, exp_din;
  logic [1:0]  m_off;
  logic        m_first, mis_m;
  logic [3:0]  exp_we;
  logic [31:0] sb_inst;

  initial begin
    rst = 1'b1;
    inst_X = NOP; addr_X = 0; rs2_X = 0; data_fwd = 0; stall = 0; flush = 0; dmem_dout = 0;
    #2;
    chk("reset_inst_M", inst_M, NOP);
    chk("reset_load_data", load_data_M, 32'h0);
    chk("reset_misalign", {31'h0, misalign}, 32'h0);
    next();
    rst = 1'b0;
    next();

    vecs[0] = '{mk(OP_STORE, 3'b000, 5'd5), 32'h00001003, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 1'b1};
    vecs[1] = '{mk(OP_STORE, 3'b001, 5'd5), 32'h00001002, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF, 1'b1};
    vecs[2] = '{mk(OP_STORE, 3'b001, 5'd6), 32'h00001000, 32'h00001234, 4'b0011, 32'h12341234, 1'b1};
    vecs[3] = '{mk(OP_STORE, 3'b000, 5'd7), 32'h00002001, 32'h12345678, 4'b0010, 32'h78787878, 1'b1};
    vecs[4] = '{mk(OP_STORE, 3'b010, 5'd8), 32'h00003000, 32'hCAFEBABE, 4'b1111, 32'hCAFEBABE, 1'b1};
    vecs[5] = '{mk(OP_STORE, 3'b001, 5'd9), 32'h00001001, 32'h11112222, 4'b0000, 32'h0, 1'b0};
    vecs[6] = '{mk(OP_STORE, 3'b010, 5'd9), 32'h00001002, 32'h33334444, 4'b0000, 32'h0, 1'b0};
    vecs[7] = '{mk(OP_LOAD,  3'b010, 5'd9), 32'h00001000, 32'h55556666, 4'b0000, 32'h0, 1'b0};
    vecs[8] = '{mk(OP_STORE, 3'b011, 5'd9), 32'h00001000, 32'h77778888, 4'b0000, 32'h0, 1'b0};

    for (int i = 0; i < 9; i++) begin
      inst_X = vecs[i].inst; addr_X = vecs[i].addr; rs2_X = vecs[i].rs2;
      #1;
      chk($sformatf("vec%0d_we", i), {28'h0, dmem_we}, {28'h0, vecs[i].we});
      chk($sformatf("vec%0d_addr", i), dmem_addr, vecs[i].addr & 32'hFFFFFFFC);
      if (vecs[i].chk_din) chk($sformatf("vec%0d_din", i), dmem_din, vecs[i].din);
    end
    do_reset();

    // Directed loads: address in X, data settles in the following (M) cycle.
    inst_X = mk(OP_LOAD, 3'b000, 5'd0); addr_X = 32'h00001001; next();
    inst_X = NOP; dmem_dout = 32'h00008000; #1;
    chk("lb_off1", load_data_M, 32'hFFFFFF80);
    next();
    inst_X = mk(OP_LOAD, 3'b100, 5'd0); addr_X = 32'h00001001; next();
    inst_X = NOP; dmem_dout = 32'h00008000; #1;
    chk("lbu_off1", load_data_M, 32'h00000080);
    next();
    inst_X = mk(OP_LOAD, 3'b001, 5'd0); addr_X = 32'h00001002; next();
    inst_X = NOP; dmem_dout = 32'h80010000; #1;
    chk("lh_off2", load_data_M, 32'hFFFF8001);
    next();
    inst_X = mk(OP_LOAD, 3'b101, 5'd0); addr_X = 32'h00001002; next();
    inst_X = NOP; dmem_dout = 32'h80010000; #1;
    chk("lhu_off2", load_data_M, 32'h00008001);
    next();

    // Load in M forwarded to store in X.
    inst_X = mk(OP_LOAD, 3'b010, 5'd0); addr_X = 32'h00000100; next();
    dmem_dout = 32'hDEADBEEF; inst_X = mk(OP_STORE, 3'b010, 5'd5); addr_X = 32'h00000200;
    data_fwd = 1'b1; rs2_X = 32'h0; #1;
    chk("fwd_din", dmem_din, 32'hDEADBEEF);
    chk("fwd_we", {28'h0, dmem_we}, 32'hF);
    next();
    data_fwd = 1'b0; inst_X = NOP;

    // Three stall cycles with a load in M; DMEM output changes underneath.
    inst_X = mk(OP_LOAD, 3'b010, 5'd0); addr_X = 32'h00000040; next();
    dmem_dout = 32'hCAFEF00D; stall = 1'b1;
    inst_X = mk(OP_STORE, 3'b010, 5'd3); addr_X = 32'h00000080; rs2_X = 32'h1; #1;
    chk("stall1_ld", load_data_M, 32'hCAFEF00D);
    chk("stall1_we", {28'h0, dmem_we}, 32'h0);
    next();
    dmem_dout = 32'h12345678; #1;
    chk("stall2_ld", load_data_M, 32'hCAFEF00D);
    chk("stall2_we", {28'h0, dmem_we}, 32'h0);
    next();
    chk("stall3_ld", load_data_M, 32'hCAFEF00D);
    stall = 1'b0; #1;
    chk("stall_release_ld", load_data_M, 32'hCAFEF00D);
    chk("stall_release_we", {28'h0, dmem_we}, 32'hF);
    next();
    inst_X = NOP;

    // Misaligned SW sets the sticky flag.
    chk("misalign_pre", {31'h0, misalign}, 32'h0);
    inst_X = mk(OP_STORE, 3'b010, 5'd2); addr_X = 32'h00001002; #1;
    chk("sw_mis_we", {28'h0, dmem_we}, 32'h0);
    next();
    chk("misalign_set", {31'h0, misalign}, 32'h1);
    inst_X = NOP; addr_X = 32'h0; next(); next();
    chk("misalign_sticky", {31'h0, misalign}, 32'h1);

    // Misaligned LW in M returns zero.
    inst_X = mk(OP_LOAD, 3'b010, 5'd0); addr_X = 32'h00000003; next();
    inst_X = NOP; dmem_dout = 32'hFFFFFFFF; #1;
    chk("lw_mis_zero", load_data_M, 32'h0);
    next();

    inst_X = mk(OP_LOAD, 3'b010, 5'd0); addr_X = 32'h0; flush = 1'b1; next();
    flush = 1'b0; dmem_dout = 32'hAAAA5555;
    chk("flush_inst_M", inst_M, NOP);
    chk("flush_ld_zero", load_data_M, 32'h0);

    sb_inst = mk(OP_STORE, 3'b000, 5'd11);
    inst_X = sb_inst; addr_X = 32'h0; next();
    inst_X = mk(OP_LOAD, 3'b010, 5'd0); stall = 1'b1; flush = 1'b1; next();
    chk("stall_flush_hold", inst_M, sb_inst);
    stall = 1'b0; flush = 1'b0;

    // Asynchronous reset with a load in M.
    inst_X = mk(OP_LOAD, 3'b010, 5'd0); addr_X = 32'h4; next();
    inst_X = NOP; dmem_dout = 32'h11223344; #1;
    chk("pre_rst_ld", load_data_M, 32'h11223344);
    rst = 1'b1; #1;
    chk("async_rst_inst_M", inst_M, NOP);
    chk("async_rst_ld", load_data_M, 32'h0);
    chk("async_rst_misalign", {31'h0, misalign}, 32'h0);
    next();
    rst = 1'b0;
    next();

    // Randomized traffic vs. reference model.
    m_inst = NOP; m_off = 2'b00; m_word = 32'h0; m_first = 1'b0; mis_m = 1'b0;
    for (int i = 0; i < 600; i++) begin
      int sel;
      sel = $urandom_range(0, 2);
      dmem_dout = $urandom;
      inst_X = {$urandom} & 32'hFFFF_FF80;
      inst_X[6:0] = (sel == 0) ? OP_LOAD : (sel == 1) ? OP_STORE : 7'b0010011;
      addr_X   = $urandom;
      rs2_X    = $urandom;
      data_fwd = $urandom_range(0, 1) == 1;
      stall    = $urandom_range(0, 3) == 0;
      flush    = $urandom_range(0, 5) == 0;
      if (m_first) m_word = dmem_dout;
      #1;
      exp_ld = load_val(m_inst, m_off, m_word);
      chk("rnd_load_data", load_data_M, exp_ld);
      chk("rnd_inst_M", inst_M, m_inst);
      chk("rnd_misalign", {31'h0, misalign}, {31'h0, mis_m});
      store_exp(inst_X, addr_X, data_fwd ? exp_ld : rs2_X, stall, exp_we, exp_din);
      chk("rnd_we", {28'h0, dmem_we}, {28'h0, exp_we});
      if (exp_we != 4'h0) chk("rnd_din", dmem_din, exp_din);
      chk("rnd_addr", dmem_addr, addr_X & 32'hFFFFFFFC);
      if (!stall) begin
        if (is_mis(inst_X, addr_X)) mis_m = 1'b1;
        m_inst  = flush ? NOP : inst_X;
        m_off   = addr_X[1:0];
        m_first = 1'b1;
      end else begin
        m_first = 1'b0;
      end
      next();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Drives the data-memory port from the Execute stage and extracts load results in the Memory stage of the 4-stage no-cache pipeline. Consumes the store-data forward select produced by the memory data-forwarding logic, aligns store data and byte enables to the address, registers the X→M state, and sign- or zero-extends the synchronous DMEM read data for writeback and forwarding.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- inst_X  in  32  instruction in X stage
- addr_X  in  32  ALU result (effective address) in X
- rs2_X  in  32  rs2 register value in X
- data_fwd  in  1  0 = store data from rs2_X, 1 = forward load_data_M
- stall  in  1  hold X and M; no DMEM write
- flush  in  1  insert bubble into M
- dmem_dout  in  32  DMEM read data, valid one cycle after address
- dmem_addr  out  32  {addr_X[31:2], 2'b00}, combinational
- dmem_din  out  32  aligned store data, combinational
- dmem_we  out  4  byte write enables, combinational
- inst_M  out  32  registered instruction in M
- load_data_M  out  32  extended load result in M
- misalign  out  1  sticky: a misaligned load/store was seen

## Operation
- Store (opcode STORE in inst_X), off = addr_X[1:0], src = data_fwd ? load_data_M : rs2_X:
  - SB: dmem_din = {4{src[7:0]}}, dmem_we = 4'b0001 << off.
  - SH: dmem_din = {2{src[15:0]}}, dmem_we = addr_X[1] ? 4'b1100 : 4'b0011.
  - SW: dmem_din = src, dmem_we = 4'b1111.
- Misaligned access: SH/LH/LHU with off[0]=1, SW/LW with off≠0. Store: dmem_we = 0. Load: load_data_M = 0 in M. Either sets misalign at next edge (unless stall).
- dmem_we = 0 when inst_X is not a store, stall=1, or funct3 is not SB/SH/SW.
- X→M registers (load when stall=0): inst_M, funct3_M, off_M, is_load_M, misal_M. flush=1 (and stall=0) loads a bubble: inst_M = 32'h00000013, is_load_M = 0.
- Load extraction in M from rd = (stall_q ? ld_hold : dmem_dout):
  - LB/LBU: byte rd[8*off_M +: 8], sign/zero extended.
  - LH/LHU: half rd[16*off_M[1] +: 16], sign/zero extended.
  - LW: rd.
  - Non-load in M: load_data_M = 0.
- Stall hold: stall_q <= stall every edge. On an edge with stall=1 and stall_q=0, ld_hold <= dmem_dout. While stall_q=1 the held word is used, since DMEM is re-reading the stalled X address.
- flush and stall both high: stall wins; M holds.
- misalign clears only on reset.

## Timing
- Reset (async, immediate): inst_M = 32'h00000013, funct3_M/off_M/is_load_M/misal_M = 0, stall_q = 0, ld_hold = 0, misalign = 0; load_data_M = 0. Combinational outputs follow inputs.
- Store: write accepted on the edge ending the X cycle. Zero latency from inputs to dmem_*.
- Load: address in cycle N (X), load_data_M valid in cycle N+1 (M) after dmem_dout settles.
- Stall of k cycles: load_data_M stays constant for all k+1 cycles the load sits in M.
- Forward path: load in M → store in X, same cycle, combinational through load_data_M to dmem_din.

## Test plan
- Reset mid-operation: assert rst with a load in M -> inst_M = 32'h00000013, load_data_M = 0, misalign = 0 immediately, without a clock edge.
- SB to addr 0x1003, rs2_X = 0x000000A5 -> dmem_we = 4'b1000, dmem_din = 0xA5A5A5A5, dmem_addr = 0x1000; SH to 0x1002 -> dmem_we = 4'b1100.
- LB from off 1 with dmem_dout = 0x0000_8000 -> load_data_M = 0xFFFFFF80; LBU -> 0x00000080; LH off 2 with dmem_dout = 0x8001_0000 -> 0xFFFF8001.
- Load-to-store forward: LW x5 (dmem_dout = 0xDEADBEEF) in M, SW x5 in X, data_fwd = 1, rs2_X = 0 -> dmem_din = 0xDEADBEEF, dmem_we = 4'b1111.
- Stall 3 cycles with an LW in M, dmem_dout changes to 0x12345678 after the first stall cycle -> load_data_M holds the original word throughout; dmem_we = 0 for a store in X during the stall.
- SW to 0x1002 -> dmem_we = 0, misalign = 1 from the next edge and stays 1; flush with stall = 0 -> inst_M = 32'h00000013 next cycle.
